// File: rtl/logic_wb_regfile.sv
`default_nettype none
// ============================================================================
// Module   : logic_wb_regfile
// Purpose  : Write-back stage of the logic datapath. Results from the logic
//            selector enter a small in-order queue through a valid/ready
//            handshake. They retire into a 2**ADDR_W-entry register file at
//            most once per cycle, and only while COMMIT_EN is high. Two
//            combinational read ports forward queued values, so reads always
//            return the newest value written to an address.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   CLK        in   1         clock, rising edge
//   RESET      in   1         asynchronous, active-high reset
//   WB_VALID   in   1         producer presents WB_ADDR/WB_DATA
//   WB_READY   out  1         queue has room (registered state only)
//   WB_ADDR    in   ADDR_W    destination register
//   WB_DATA    in   DATA_W    result value
//   COMMIT_EN  in   1         allow the head entry to retire this cycle
//   RD_ADDR1/2 in   ADDR_W    read addresses
//   RD_DATA1/2 out  DATA_W    read data (combinational, forwarded)
//   PENDING    out  ADDR_W+1  number of queued entries
//   BUSY       out  1         queue not empty
// ============================================================================
module logic_wb_regfile #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              WB_VALID,
  output logic              WB_READY,
  input  logic [ADDR_W-1:0] WB_ADDR,
  input  logic [DATA_W-1:0] WB_DATA,
  input  logic              COMMIT_EN,
  input  logic [ADDR_W-1:0] RD_ADDR1,
  output logic [DATA_W-1:0] RD_DATA1,
  input  logic [ADDR_W-1:0] RD_ADDR2,
  output logic [DATA_W-1:0] RD_DATA2,
  output logic [ADDR_W:0]   PENDING,
  output logic              BUSY
);

  localparam int NREGS = 2 ** ADDR_W;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W:0]   DEPTH_SUM = (PTR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] regs   [NREGS];
  logic [ADDR_W-1:0] q_addr [DEPTH];
  logic [DATA_W-1:0] q_data [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;
  logic              accept;
  logic              commit;

  // Ready is a pure function of the occupancy register, so a producer can
  // rely on it without any combinational path from its own VALID.
  assign WB_READY = (count < DEPTH_CNT);
  assign accept   = WB_VALID & WB_READY;
  // An entry accepted on this edge is not yet counted, so it can only
  // retire on a later edge.
  assign commit   = COMMIT_EN & (count != '0);
  assign PENDING  = count;
  assign BUSY     = (count != '0);

  // Explicit wrap keeps non-power-of-two depths correct.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_addr[i] <= '0;
        q_data[i] <= '0;
      end
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      // accept and commit never touch the same slot: that would need the
      // queue to be simultaneously full (no accept) or empty (no commit).
      if (accept) begin
        q_addr[tail] <= WB_ADDR;
        q_data[tail] <= WB_DATA;
        tail         <= ptr_inc(tail);
      end
      if (commit) begin
        regs[q_addr[head]] <= q_data[head];
        head               <= ptr_inc(head);
      end
      case ({accept, commit})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Forwarding: walk the live entries oldest to youngest so the last match
  // (the youngest) overrides the array value.
  logic [PTR_W:0]   slot_sum;
  logic [PTR_W-1:0] slot;

  always_comb begin
    RD_DATA1 = regs[RD_ADDR1];
    RD_DATA2 = regs[RD_ADDR2];
    slot_sum = '0;
    slot     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot_sum = {1'b0, head} + (PTR_W + 1)'(i);
      if (slot_sum >= DEPTH_SUM) slot_sum = slot_sum - DEPTH_SUM;
      slot = slot_sum[PTR_W-1:0];
      if (CNT_W'(i) < count) begin
        if (q_addr[slot] == RD_ADDR1) RD_DATA1 = q_data[slot];
        if (q_addr[slot] == RD_ADDR2) RD_DATA2 = q_data[slot];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_logic_wb_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_logic_wb_regfile
// Purpose  : Self-checking bench for logic_wb_regfile. Directed scenarios
//            followed by random traffic, compared against a queue-plus-array
//            reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_logic_wb_regfile;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 2;
  localparam int NREGS  = 8;

  logic              CLK = 1'b0;
  logic              RESET;
  logic              WB_VALID;
  logic              WB_READY;
  logic [ADDR_W-1:0] WB_ADDR;
  logic [DATA_W-1:0] WB_DATA;
  logic              COMMIT_EN;
  logic [ADDR_W-1:0] RD_ADDR1;
  logic [DATA_W-1:0] RD_DATA1;
  logic [ADDR_W-1:0] RD_ADDR2;
  logic [DATA_W-1:0] RD_DATA2;
  logic [ADDR_W:0]   PENDING;
  logic              BUSY;

  logic_wb_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RESET(RESET),
    .WB_VALID(WB_VALID), .WB_READY(WB_READY),
    .WB_ADDR(WB_ADDR), .WB_DATA(WB_DATA),
    .COMMIT_EN(COMMIT_EN),
    .RD_ADDR1(RD_ADDR1), .RD_DATA1(RD_DATA1),
    .RD_ADDR2(RD_ADDR2), .RD_DATA2(RD_DATA2),
    .PENDING(PENDING), .BUSY(BUSY)
  );

  always #10 CLK = ~CLK;

  // Reference model: pending results in arrival order, plus the array.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t            mq[$];
  logic [DATA_W-1:0] mrf [NREGS];

  int checks   = 0;
  int failures = 0;

  function automatic logic [DATA_W-1:0] exp_read(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    v = mrf[a];
    foreach (mq[i]) if (mq[i].addr == a) v = mq[i].data;
    return v;
  endfunction

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < NREGS; i++) mrf[i] = '0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Status outputs, then every address on both read ports (1 ns apart).
  task automatic check_state(input string tag, input bit same);
    logic [ADDR_W-1:0] a1, a2;
    chk($sformatf("%s pending", tag), 32'(PENDING), 32'(mq.size()));
    chk($sformatf("%s ready", tag), 32'(WB_READY), 32'(mq.size() < DEPTH));
    chk($sformatf("%s busy", tag), 32'(BUSY), 32'(mq.size() != 0));
    for (int a = 0; a < NREGS; a++) begin
      a1 = ADDR_W'(a);
      a2 = same ? a1 : ADDR_W'(a * 5 + 1);
      RD_ADDR1 = a1;
      RD_ADDR2 = a2;
      #1;
      chk($sformatf("%s rd1[%0d]", tag, a1), 32'(RD_DATA1), 32'(exp_read(a1)));
      chk($sformatf("%s rd2[%0d]", tag, a2), 32'(RD_DATA2), 32'(exp_read(a2)));
    end
  endtask

  // One clock cycle: drive, predict from pre-edge model state, advance model.
  task automatic step(input bit v, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d, input bit ce,
                      input string tag, input bit same);
    bit     acc, com;
    entry_t e;
    WB_VALID  = v;
    WB_ADDR   = a;
    WB_DATA   = d;
    COMMIT_EN = ce;
    acc = v && (mq.size() < DEPTH);
    com = ce && (mq.size() != 0);
    @(posedge CLK);
    if (com) begin
      e = mq.pop_front();
      mrf[e.addr] = e.data;
    end
    if (acc) begin
      e.addr = a;
      e.data = d;
      mq.push_back(e);
    end
    #1;
    check_state(tag, same);
  endtask

  logic [DATA_W-1:0] wrap_vals [5];

  initial begin
    RESET = 1'b1; WB_VALID = 1'b0; WB_ADDR = '0; WB_DATA = '0;
    COMMIT_EN = 1'b0; RD_ADDR1 = '0; RD_ADDR2 = '0;
    model_reset();
    repeat (2) @(posedge CLK);
    #5;
    RESET = 1'b0;
    check_state("reset", 1'b1);

    // Single write with commit enabled: forwarded, then retired.
    step(1'b1, 3'd3, 8'd54, 1'b1, "w3", 1'b1);
    step(1'b0, 3'd0, 8'd0, 1'b1, "w3_drain", 1'b1);

    // Two writes to the same register with commit held off.
    step(1'b1, 3'd1, 8'd2,  1'b0, "w1a", 1'b0);
    step(1'b1, 3'd1, 8'd14, 1'b0, "w1b", 1'b0);
    step(1'b1, 3'd1, 8'd99, 1'b0, "full_ignored", 1'b1);
    step(1'b0, 3'd0, 8'd0,  1'b1, "c1", 1'b0);
    step(1'b0, 3'd0, 8'd0,  1'b1, "c2", 1'b1);

    // Full queue, then commit with VALID held: one retire per edge.
    step(1'b1, 3'd5, 8'h11, 1'b0, "fill1", 1'b0);
    step(1'b1, 3'd6, 8'h22, 1'b0, "fill2", 1'b0);
    for (int i = 0; i < 5; i++)
      step(1'b1, 3'd7, 8'(8'h33 + i), 1'b1, "held", 1'b0);
    step(1'b0, 3'd0, 8'd0, 1'b1, "held_drain1", 1'b1);
    step(1'b0, 3'd0, 8'd0, 1'b1, "held_drain2", 1'b1);

    // Pointer wrap with a steady accept/commit stream.
    wrap_vals[0] = 8'd27; wrap_vals[1] = 8'd14; wrap_vals[2] = 8'd7;
    wrap_vals[3] = 8'd2;  wrap_vals[4] = 8'd54;
    for (int i = 0; i < 5; i++)
      step(1'b1, ADDR_W'(i), wrap_vals[i], 1'b1, "wrap", 1'b0);
    step(1'b0, 3'd0, 8'd0, 1'b1, "wrap_drain1", 1'b1);
    step(1'b0, 3'd0, 8'd0, 1'b1, "wrap_drain2", 1'b1);
    for (int i = 0; i < 5; i++) begin
      RD_ADDR1 = ADDR_W'(i);
      #1;
      chk($sformatf("wrap_final[%0d]", i), 32'(RD_DATA1), 32'(wrap_vals[i]));
    end

    // Reset between edges with two entries queued.
    step(1'b1, 3'd2, 8'hA5, 1'b0, "pre_rst1", 1'b0);
    step(1'b1, 3'd6, 8'h5A, 1'b0, "pre_rst2", 1'b0);
    WB_VALID = 1'b0;
    RESET    = 1'b1;
    model_reset();
    #1;
    check_state("in_reset", 1'b1);
    RESET = 1'b0;
    step(1'b0, 3'd0, 8'd0, 1'b1, "post_rst1", 1'b1);
    step(1'b0, 3'd0, 8'd0, 1'b1, "post_rst2", 1'b0);

    // Random traffic.
    for (int i = 0; i < 300; i++)
      step(bit'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, NREGS - 1)),
           DATA_W'($urandom), $urandom_range(0, 3) != 0, "rand",
           bit'($urandom_range(0, 1)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
